// File: rtl/vga_term_pkg.sv
// Shared encodings for the text-terminal controller: opcodes, register map,
// CSR bit positions, engine FSM states and screen geometry.
package vga_term_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR_SCREEN = 2'b00,
        OP_SCROLL       = 2'b01,
        OP_CLEAR_LINE   = 2'b10,
        OP_RESERVED     = 2'b11
    } op_e;

    localparam logic [1:0] REG_CSR    = 2'd0;
    localparam logic [1:0] REG_CURSOR = 2'd1;
    localparam logic [1:0] REG_FILL   = 2'd2;
    localparam logic [1:0] REG_LINE   = 2'd3;

    localparam int CSR_GO          = 0;
    localparam int CSR_OP_LO       = 1;
    localparam int CSR_CURSOR_ON   = 4;
    localparam int CSR_CURSOR_TYPE = 5;
    localparam int CSR_DONE        = 6;
    localparam int CSR_IE          = 7;
    localparam int CSR_BUSY        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU,
        ST_E_RD,
        ST_E_WR,
        ST_FIN
    } state_e;

    localparam int SCREEN_WORDS = 1000;
    localparam int FIRST_WORD   = 40;
    localparam int LAST_WORD    = SCREEN_WORDS - 1;

endpackage

// File: rtl/vga_flash_gen.sv
// Free-running divider producing the character flash square wave;
// the output toggles every FLASH_DIV clocks.
module vga_flash_gen #(
    parameter int FLASH_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic flash
);

    logic [24:0] cnt_reg;
    logic        flash_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            flash_reg <= 1'b0;
        end else if (cnt_reg == 25'(FLASH_DIV - 1)) begin
            cnt_reg   <= '0;
            flash_reg <= ~flash_reg;
        end else begin
            cnt_reg <= cnt_reg + 25'd1;
        end
    end

    assign flash = flash_reg;

endmodule

// File: rtl/vga_term_ctl.sv
// Terminal controller: arbitrates the VGA VRAM wishbone port between CPU
// pass-through and a fill/scroll engine, and holds cursor/flash state.
module vga_term_ctl
    import vga_term_pkg::*;
#(
    parameter int FLASH_DIV  = 25000000,
    parameter int LINE_WORDS = 40,
    parameter int LINES      = 25
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [15:0] s_adr_i,
    input  logic [15:0] s_dat_i,
    output logic [15:0] s_dat_o,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [1:0]  s_sel_i,
    output logic        s_ack_o,
    output logic [15:0] m_adr_o,
    output logic [15:0] m_dat_o,
    input  logic [15:0] m_dat_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [1:0]  m_sel_o,
    input  logic        m_ack_i,
    output logic [12:0] cursor,
    output logic        cursor_on,
    output logic        cursor_type,
    output logic        flash,
    output logic        irq
);

    localparam logic [9:0] FIRST_W   = 10'(FIRST_WORD);
    localparam logic [9:0] LAST_W    = 10'(LAST_WORD);
    localparam logic [9:0] STRIDE    = 10'(LINE_WORDS);
    localparam logic [9:0] COPY_LAST = 10'(LAST_WORD - LINE_WORDS);

    state_e      state_reg;
    logic        reg_ack_reg;
    logic [15:0] reg_rdata_reg;
    op_e         op_reg;
    logic        cursor_on_reg, cursor_type_reg, done_reg, ie_reg, busy_reg;
    logic [12:0] cursor_reg;
    logic [15:0] fill_reg;
    logic [4:0]  line_reg;
    logic [9:0]  dst_reg, last_reg;
    logic        scroll_reg, empty_reg;
    logic [15:0] fill_run_reg, rd_data_reg;

    logic        vram_req, reg_cycle, reg_wr, csr_wr, start, done_clr;
    logic        line_ok, copy_phase, unused_line_msb;
    logic [1:0]  reg_off;
    logic [10:0] line_base;
    logic [15:0] csr_word, reg_word;

    assign vram_req  = s_cyc_i & s_stb_i & ~s_adr_i[12];
    // Register ack pulses one cycle after the request, then gaps a cycle.
    assign reg_cycle = s_cyc_i & s_stb_i & s_adr_i[12] & ~reg_ack_reg;
    assign reg_wr    = reg_cycle & s_we_i;
    assign reg_off   = s_adr_i[2:1];
    assign csr_wr    = reg_wr & (reg_off == REG_CSR) & s_sel_i[0];
    assign start     = csr_wr & s_dat_i[CSR_GO] & ~busy_reg
                       & (s_dat_i[2:1] != OP_RESERVED);
    assign done_clr  = csr_wr & s_dat_i[CSR_DONE];

    assign line_base       = 11'(line_reg) * 11'(LINE_WORDS);
    assign line_ok         = {27'd0, line_reg} < 32'(LINES);
    assign unused_line_msb = line_base[10];
    assign copy_phase      = scroll_reg & (dst_reg <= COPY_LAST);

    assign csr_word = {7'd0, busy_reg, ie_reg, done_reg, cursor_type_reg,
                       cursor_on_reg, 1'b0, op_reg, busy_reg};

    always_comb begin
        reg_word = csr_word;
        case (reg_off)
            REG_CURSOR: reg_word = {3'd0, cursor_reg};
            REG_FILL:   reg_word = fill_reg;
            REG_LINE:   reg_word = {11'd0, line_reg};
            default:    reg_word = csr_word;
        endcase
    end

    always_comb begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_sel_o = 2'b00;
        m_adr_o = '0;
        m_dat_o = '0;
        case (state_reg)
            ST_CPU: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_we_o  = s_we_i;
                m_sel_o = s_sel_i;
                m_adr_o = s_adr_i;
                m_dat_o = s_dat_i;
            end
            ST_E_RD: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_sel_o = 2'b11;
                m_adr_o = {5'd0, dst_reg + STRIDE, 1'b0};
            end
            ST_E_WR: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_sel_o = 2'b11;
                m_adr_o = {5'd0, dst_reg, 1'b0};
                m_dat_o = copy_phase ? rd_data_reg : fill_run_reg;
            end
            default: ;
        endcase
    end

    assign s_ack_o = ((state_reg == ST_CPU) & m_ack_i) | reg_ack_reg;
    assign s_dat_o = (state_reg == ST_CPU) ? m_dat_i : reg_rdata_reg;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_reg       <= ST_IDLE;
            reg_ack_reg     <= 1'b0;
            reg_rdata_reg   <= '0;
            op_reg          <= OP_CLEAR_SCREEN;
            cursor_on_reg   <= 1'b0;
            cursor_type_reg <= 1'b0;
            done_reg        <= 1'b0;
            ie_reg          <= 1'b0;
            busy_reg        <= 1'b0;
            cursor_reg      <= '0;
            fill_reg        <= '0;
            line_reg        <= '0;
            dst_reg         <= '0;
            last_reg        <= '0;
            scroll_reg      <= 1'b0;
            empty_reg       <= 1'b0;
            fill_run_reg    <= '0;
            rd_data_reg     <= '0;
        end else begin
            reg_ack_reg <= reg_cycle;
            if (reg_cycle) reg_rdata_reg <= reg_word;

            if (reg_wr) begin
                case (reg_off)
                    REG_CSR: if (s_sel_i[0]) begin
                        cursor_on_reg   <= s_dat_i[CSR_CURSOR_ON];
                        cursor_type_reg <= s_dat_i[CSR_CURSOR_TYPE];
                        ie_reg          <= s_dat_i[CSR_IE];
                        if (!busy_reg) op_reg <= op_e'(s_dat_i[CSR_OP_LO +: 2]);
                    end
                    REG_CURSOR: begin
                        if (s_sel_i[0]) cursor_reg[7:0]  <= s_dat_i[7:0];
                        if (s_sel_i[1]) cursor_reg[12:8] <= s_dat_i[12:8];
                    end
                    REG_FILL: begin
                        if (s_sel_i[0]) fill_reg[7:0]  <= s_dat_i[7:0];
                        if (s_sel_i[1]) fill_reg[15:8] <= s_dat_i[15:8];
                    end
                    default: if (s_sel_i[0]) line_reg <= s_dat_i[4:0];
                endcase
            end

            if (state_reg == ST_FIN) done_reg <= 1'b1;
            else if (done_clr)       done_reg <= 1'b0;

            if (start) begin
                busy_reg     <= 1'b1;
                fill_run_reg <= fill_reg;
                scroll_reg   <= (s_dat_i[2:1] == OP_SCROLL);
                empty_reg    <= 1'b0;
                dst_reg      <= FIRST_W;
                last_reg     <= LAST_W;
                // Out-of-range line: run straight to FIN with no bus cycles.
                if (s_dat_i[2:1] == OP_CLEAR_LINE) begin
                    if (line_ok) begin
                        dst_reg  <= line_base[9:0];
                        last_reg <= line_base[9:0] + STRIDE - 10'd1;
                    end else begin
                        empty_reg <= 1'b1;
                    end
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (vram_req)        state_reg <= ST_CPU;
                    else if (busy_reg) begin
                        if (empty_reg)       state_reg <= ST_FIN;
                        else if (copy_phase) state_reg <= ST_E_RD;
                        else                 state_reg <= ST_E_WR;
                    end
                end
                ST_CPU: if (m_ack_i) state_reg <= ST_IDLE;
                ST_E_RD: if (m_ack_i) begin
                    rd_data_reg <= m_dat_i;
                    state_reg   <= ST_E_WR;
                end
                ST_E_WR: if (m_ack_i) begin
                    if (dst_reg == last_reg) begin
                        state_reg <= ST_FIN;
                    end else begin
                        dst_reg   <= dst_reg + 10'd1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FIN: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cursor      = cursor_reg;
    assign cursor_on   = cursor_on_reg;
    assign cursor_type = cursor_type_reg;
    assign irq         = done_reg & ie_reg;

    vga_flash_gen #(.FLASH_DIV(FLASH_DIV)) u_flash (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .flash (flash)
    );

endmodule

// File: tb/tb_vga_term_ctl.sv
// Directed bench for vga_term_ctl with a behavioural VRAM slave model.
module tb_vga_term_ctl;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic [15:0] s_adr_i = '0, s_dat_i = '0, s_dat_o;
    logic        s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0, s_ack_o;
    logic [1:0]  s_sel_i = 2'b11;
    logic [15:0] m_adr_o, m_dat_o, m_dat_i;
    logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i;
    logic [1:0]  m_sel_o;
    logic [12:0] cursor;
    logic        cursor_on, cursor_type, flash, irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    vga_term_ctl #(.FLASH_DIV(4), .LINE_WORDS(40), .LINES(25)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
        .s_sel_i(s_sel_i), .s_ack_o(s_ack_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_sel_o(m_sel_o), .m_ack_i(m_ack_i),
        .cursor(cursor), .cursor_on(cursor_on), .cursor_type(cursor_type),
        .flash(flash), .irq(irq)
    );

    // VRAM slave: acks one cycle after strobe, then gaps one cycle.
    logic [15:0] mem [0:2047];
    logic        vga_ack = 1'b0;
    logic [15:0] vga_rdata = '0;
    int          wr_cnt = 0, rd_cnt = 0, cyc_cnt = 0, cmd = 0;
    logic [15:0] wr_min = 16'hFFFF, wr_max = 16'h0000;

    assign m_ack_i = vga_ack;
    assign m_dat_i = vga_rdata;

    always @(posedge wb_clk_i) begin
        if (cmd == 1 || cmd == 2) begin
            wr_cnt = 0; rd_cnt = 0; cyc_cnt = 0;
            wr_min = 16'hFFFF; wr_max = 16'h0000;
        end
        if (cmd == 2)
            for (int k = 0; k < 2048; k++) mem[k] = 16'(k);
        if (!wb_rst_n_i) begin
            vga_ack <= 1'b0;
        end else begin
            if (m_cyc_o) cyc_cnt++;
            vga_ack <= m_cyc_o & m_stb_o & ~vga_ack;
            if (m_cyc_o & m_stb_o & ~vga_ack) begin
                if (m_we_o) begin
                    if (m_sel_o[0]) mem[m_adr_o[11:1]][7:0]  = m_dat_o[7:0];
                    if (m_sel_o[1]) mem[m_adr_o[11:1]][15:8] = m_dat_o[15:8];
                    wr_cnt++;
                    if (m_adr_o < wr_min) wr_min = m_adr_o;
                    if (m_adr_o > wr_max) wr_max = m_adr_o;
                end else begin
                    vga_rdata <= mem[m_adr_o[11:1]];
                    rd_cnt++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("[TB] %s observed=0x%0h", tag, obs);
    endtask

    task automatic model_cmd(input int c);
        @(negedge wb_clk_i); cmd = c;
        @(negedge wb_clk_i); cmd = 0;
    endtask

    task automatic wb_xfer(input logic [15:0] adr, input logic [15:0] dat, input logic we,
                           output logic [15:0] rdat, output logic ok, output int lat);
        @(negedge wb_clk_i);
        s_adr_i = adr; s_dat_i = dat; s_we_i = we; s_sel_i = 2'b11;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        ok = 1'b0; lat = 0; rdat = '0;
        for (int i = 0; i < 100; i++) begin
            @(posedge wb_clk_i); #1;
            lat++;
            if (s_ack_o) begin
                rdat = s_dat_o; ok = 1'b1;
                break;
            end
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    endtask

    task automatic reg_wr(input string tag, input logic [1:0] off, input logic [15:0] dat);
        logic [15:0] d; logic ok; int lat;
        wb_xfer({13'h200, off, 1'b0}, dat, 1'b1, d, ok, lat);
        chk({tag, " ack"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic reg_rd(input string tag, input logic [1:0] off, input logic [15:0] exp);
        logic [15:0] d; logic ok; int lat;
        wb_xfer({13'h200, off, 1'b0}, 16'h0, 1'b0, d, ok, lat);
        chk(tag, {15'd0, ok, d}, {15'd0, 1'b1, exp});
    endtask

    task automatic wait_idle(input string tag);
        logic [15:0] d; logic ok; int lat; logic seen;
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            wb_xfer(16'h1000, 16'h0, 1'b0, d, ok, lat);
            if (ok && !d[8]) begin seen = 1'b1; break; end
        end
        chk({tag, " idle"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic [15:0] d; logic ok; int lat; int bad;

        // Reset mid-scroll
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i) wb_rst_n_i = 1'b1;
        model_cmd(2);
        reg_wr("pre fill", 2'd2, 16'h1234);
        reg_wr("pre line", 2'd3, 16'h0003);
        reg_wr("pre cursor", 2'd1, 16'h0055);
        reg_wr("pre csr", 2'd0, 16'h00B3);
        repeat (30) @(posedge wb_clk_i);
        chk("engine active", {31'd0, (cyc_cnt > 0)}, 32'd1);
        @(negedge wb_clk_i) wb_rst_n_i = 1'b0;
        @(posedge wb_clk_i); #1;
        chk("rst m_cyc", {31'd0, m_cyc_o}, 32'd0);
        chk("rst outs", {16'd0, cursor, cursor_on, cursor_type, irq}, 32'd0);
        chk("rst flash", {31'd0, flash}, 32'd0);
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i) wb_rst_n_i = 1'b1;

        // Flash with divide-by-4
        repeat (3) @(posedge wb_clk_i); #1;
        chk("flash e3", {31'd0, flash}, 32'd0);
        @(posedge wb_clk_i); #1;
        chk("flash e4", {31'd0, flash}, 32'd1);
        repeat (3) @(posedge wb_clk_i); #1;
        chk("flash e7", {31'd0, flash}, 32'd1);
        @(posedge wb_clk_i); #1;
        chk("flash e8", {31'd0, flash}, 32'd0);

        reg_rd("rst csr", 2'd0, 16'h0000);
        reg_rd("rst cursor", 2'd1, 16'h0000);
        reg_rd("rst fill", 2'd2, 16'h0000);
        reg_rd("rst line", 2'd3, 16'h0000);

        // Clear screen
        model_cmd(2);
        reg_wr("cs fill", 2'd2, 16'h2020);
        reg_wr("cs go", 2'd0, 16'h0001);
        wait_idle("cs");
        chk("cs writes", wr_cnt, 960);
        chk("cs reads", rd_cnt, 0);
        chk("cs min adr", {16'd0, wr_min}, 32'h050);
        chk("cs max adr", {16'd0, wr_max}, 32'h7CE);
        bad = 0;
        for (int k = 0; k < 1000; k++)
            if (mem[k] !== ((k < 40) ? 16'(k) : 16'h2020)) bad++;
        chk("cs contents", bad, 0);
        reg_rd("cs csr", 2'd0, 16'h0040);

        // Scroll with CPU read, cursor write and ignored GO while busy
        model_cmd(2);
        reg_wr("sc fill", 2'd2, 16'h0720);
        reg_wr("sc go", 2'd0, 16'h0003);
        repeat (20) @(posedge wb_clk_i);
        wb_xfer(16'h0100, 16'h0, 1'b0, d, ok, lat);
        chk("cpu rd data", {15'd0, ok, d}, {15'd0, 1'b1, 16'h0080});
        chk("cpu rd latency", {31'd0, (lat <= 10)}, 32'd1);
        reg_wr("sc cursor", 2'd1, 16'h07CF);
        chk("cursor busy", {19'd0, cursor}, 32'h07CF);
        reg_wr("sc go busy", 2'd0, 16'h0005);
        reg_rd("sc csr busy", 2'd0, 16'h0143);
        wait_idle("sc");
        chk("sc word40", {16'd0, mem[40]}, 32'd80);
        chk("sc word959", {16'd0, mem[959]}, 32'd999);
        chk("sc word960", {16'd0, mem[960]}, 32'h0720);
        chk("sc word999", {16'd0, mem[999]}, 32'h0720);
        bad = 0;
        for (int k = 0; k < 1000; k++)
            if (mem[k] !== ((k < 40) ? 16'(k) : (k < 960) ? 16'(k + 40) : 16'h0720)) bad++;
        chk("sc contents", bad, 0);
        chk("sc reads", rd_cnt, 921);
        chk("sc writes", wr_cnt, 960);

        // Clear line 2
        model_cmd(2);
        reg_wr("cl line", 2'd3, 16'h0002);
        reg_wr("cl go", 2'd0, 16'h0005);
        wait_idle("cl");
        chk("cl writes", wr_cnt, 40);
        chk("cl min adr", {16'd0, wr_min}, 32'h0A0);
        chk("cl max adr", {16'd0, wr_max}, 32'h0EE);
        chk("cl word119", {16'd0, mem[119]}, 32'h0720);
        chk("cl word120", {16'd0, mem[120]}, 32'd120);

        // Out-of-range line with interrupt
        reg_wr("oor clr done", 2'd0, 16'h0040);
        reg_rd("oor csr0", 2'd0, 16'h0000);
        reg_wr("oor line", 2'd3, 16'h0019);
        model_cmd(1);
        reg_wr("oor go", 2'd0, 16'h0085);
        chk("oor irq e0", {31'd0, irq}, 32'd0);
        @(posedge wb_clk_i); #1;
        chk("oor irq e1", {31'd0, irq}, 32'd0);
        @(posedge wb_clk_i); #1;
        chk("oor irq e2", {31'd0, irq}, 32'd1);
        reg_rd("oor csr", 2'd0, 16'h00C4);
        chk("oor no cyc", cyc_cnt, 0);
        reg_wr("oor w1c", 2'd0, 16'h00C0);
        chk("oor irq clr", {31'd0, irq}, 32'd0);
        reg_rd("oor csr clr", 2'd0, 16'h0080);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_term_ctl.md
Name: vga_term_ctl

Overview:
Terminal controller in front of the text VGA adapter's wishbone VRAM port. It arbitrates that port between CPU pass-through accesses and a hardware fill/scroll engine. It also holds the cursor and cursor-mode registers and generates the character flash clock. Sits between the CPU wishbone bus and the vga block; its outputs drive vga's wishbone slave inputs and its cursor, cursor_on, cursor_type and flash inputs.

Parameters:
FLASH_DIV, 25000000, wb_clk_i cycles per flash toggle (about 1 Hz at 50 MHz); minimum 2.
LINE_WORDS, 40, 16-bit words per text line (80 chars).
LINES, 25, text lines per screen; line 0 is the service/status line.

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_n_i  in  1  reset, synchronous, active-low
s_adr_i  in  16  CPU slave byte address; bit12=0 selects the VRAM window, bit12=1 selects the registers
s_dat_i  in  16  CPU write data
s_dat_o  out  16  CPU read data
s_cyc_i, s_stb_i, s_we_i  in  1 each  CPU wishbone controls
s_sel_i  in  2  CPU byte selects
s_ack_o  out  1  CPU acknowledge
m_adr_o  out  16  to vga wb_adr_i
m_dat_o  out  16  to vga wb_dat_i
m_dat_i  in  16  from vga wb_dat_o
m_cyc_o, m_stb_o, m_we_o  out  1 each  to vga
m_sel_o  out  2  to vga
m_ack_i  in  1  from vga wb_ack_o
cursor  out  13  character address of the cursor
cursor_on, cursor_type  out  1 each  cursor visible / cursor is a block
flash  out  1  flash square wave
irq  out  1  level; done & ie

Behaviour:
- Reset (wb_rst_n_i=0 at a clock edge) forces all outputs to 0 (flash=0, irq=0) and all registers to 0. FSM returns to IDLE. Any in-flight master cycle is dropped at once (m_cyc_o=0), including mid-operation.
- Register map, word offset s_adr_i[2:1]:
  0 CSR: [0] GO (W1 starts an operation, reads as busy); [2:1] OP (00 clear screen, 01 scroll up, 10 clear line, 11 reserved = no-op); [4] cursor_on; [5] cursor_type; [6] done (sticky, W1C); [7] ie; [8] busy (RO).
  1 CURSOR: [12:0].
  2 FILL: [15:0], fill word of two characters.
  3 LINE: [4:0], target line for clear line.
- Register access: s_ack_o is asserted exactly 1 cycle after s_cyc_i&s_stb_i, then dropped for one cycle, which gives the same pulse pattern as vga. Byte writes honour s_sel_i. Register access is never stalled by the engine.
- Writing GO=1 while busy is ignored; OP is not updated. CURSOR, FILL and LINE writes while busy take effect at once; the engine samples FILL and LINE only at start.
- FSM states: IDLE, CPU, E_RD, E_WR, FIN.
  - IDLE: a CPU VRAM request wins over the engine → CPU. Otherwise busy → E_RD (scroll copy phase) or E_WR.
  - CPU: forward s_adr/dat/we/sel and assert m_cyc/m_stb. s_ack_o mirrors m_ack_i; s_dat_o = m_dat_i. Return to IDLE on m_ack_i.
  - E_RD: read word src = dst+LINE_WORDS; latch m_dat_i on ack → E_WR.
  - E_WR: write m_sel_o=11 to dst. On ack, increment dst. At the end of range → FIN, otherwise → IDLE, so the CPU is arbitrated between every engine transaction.
  - FIN: busy=0, done=1 → IDLE.
- Master strobe is held until m_ack_i and dropped in the ack cycle. Master addresses are byte addresses: m_adr_o = word_index<<1.
- Operation ranges, word indices:
  - clear screen: write FILL to 40..999; line 0 is preserved.
  - scroll up: copy 80..999 → 40..959 (read then write per word), then fill 960..999 with FILL.
  - clear line: L*40..L*40+39. L≥LINES → no memory cycles; done is set 2 cycles after the GO write.
- Flash: 25-bit counter. flash toggles when the counter reaches FLASH_DIV-1, then the counter wraps to 0. Free-running and independent of the FSM.
- A done set and a W1C clear in the same cycle: set wins.

Decomposition:
- Package vga_term_pkg holds: OP encodings, register offsets, CSR bit positions, the FSM state enum, and the constants FIRST_WORD=40, LAST_WORD=999, SCREEN_WORDS=1000.
- One natural sub-module, vga_flash_gen (divider with FLASH_DIV). Everything else stays in one module.

Test Plan:
- Reset: hold wb_rst_n_i=0 for 3 clocks during a scroll → m_cyc_o=0 next edge; all registers read 0; flash=0.
- FILL=0x2020, CSR=0x0001 (clear screen) with a vga model → exactly 960 writes to byte addresses 0x050..0x7CE, data 0x2020; done=1, busy=0; address 0x000 untouched.
- Preload word k with value k; CSR=0x0003 (scroll) → word 40 holds 80, word 959 holds 999, words 960..999 hold FILL; 920 reads plus 960 writes in total.
- CPU VRAM read of address 0x0100 mid-scroll → serviced within one engine transaction; data correct; the engine continues without a skipped word.
- LINE=25, OP=10, GO → no m_cyc_o; done set 2 cycles later; with ie=1, irq=1; writing CSR bit6 clears done and irq.
- FLASH_DIV=4 → flash toggles every 4 clocks; CURSOR=0x07CF written while busy → cursor=0x07CF next cycle.
